// File: rtl/rgmii_tx_serializer.sv
// RGMII transmit serializer.
//
// Converts a GMII byte stream into the rising/falling-edge bit pairs that
// feed the TXC, TD[3:0] and TX_CTL output DDR registers. The block runs from
// one clock. At 1G it consumes one byte per cycle. At 10M/100M it divides clk
// down to TXC and consumes one byte every two TXC periods, low nibble first.
// A new speed is taken up only at an idle byte boundary, so a frame in flight
// is never cut short and no partial TXC period is produced.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   speed[1:0]           requested speed: 10/11 = 1G, 01 = 100M, 00 = 10M
//   gmii_txd[7:0]        MAC byte, sampled when gmii_tx_clk_en = 1
//   gmii_tx_en/er        MAC enable / error, sampled with the byte
//   gmii_tx_clk_en       byte strobe back to the MAC
//   txc_d1/txc_d2        TXC ODDR rising/falling bits
//   txd_d1/txd_d2        TD ODDR rising/falling nibbles
//   txctl_d1/txctl_d2    TX_CTL ODDR rising/falling bits
//   speed_active[1:0]    speed in effect (11 reported as 10)
//   speed_change         one-cycle pulse when speed_active changes
module rgmii_tx_serializer #(
  parameter int unsigned CLK_DIV_100M = 5,
  parameter int unsigned CLK_DIV_10M  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       gmii_tx_clk_en,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       txctl_d1,
  output logic       txctl_d2,
  output logic [1:0] speed_active,
  output logic       speed_change
);

  localparam int unsigned DivMax = (CLK_DIV_10M > CLK_DIV_100M) ? CLK_DIV_10M : CLK_DIV_100M;
  localparam int unsigned CntW   = (DivMax > 1) ? $clog2(DivMax) : 1;

  localparam logic [CntW-1:0] Last100M = CntW'(CLK_DIV_100M - 1);
  localparam logic [CntW-1:0] Last10M  = CntW'(CLK_DIV_10M - 1);
  localparam logic [CntW-1:0] Half100M = CntW'(CLK_DIV_100M / 2);
  localparam logic [CntW-1:0] Half10M  = CntW'(CLK_DIV_10M / 2);

  localparam logic [1:0] Spd1G   = 2'b10;
  localparam logic [1:0] Spd100M = 2'b01;

  // Core state
  logic [1:0]      speed_q, speed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [7:0]      byte_q, byte_d;
  logic            en_q, en_d;
  logic            er_q, er_d;

  // Registered outputs
  logic       clk_en_q, clk_en_d;
  logic       txc_rise_q, txc_rise_d;
  logic       txc_fall_q, txc_fall_d;
  logic [3:0] txd_rise_q, txd_rise_d;
  logic [3:0] txd_fall_q, txd_fall_d;
  logic       ctl_rise_q, ctl_rise_d;
  logic       ctl_fall_q, ctl_fall_d;
  logic       chg_q, chg_d;

  // Decode of the current state
  logic [1:0]      req_speed;
  logic            slow_q;
  logic [CntW-1:0] last_q;
  logic            period_end;
  logic            boundary;
  logic            adopt;

  always_comb begin
    req_speed  = (speed == 2'b11) ? Spd1G : speed;
    slow_q     = (speed_q != Spd1G);
    last_q     = (speed_q == Spd100M) ? Last100M : Last10M;
    period_end = (cnt_q == last_q);
    // At 1G every cycle is a byte slot; at 10M/100M the slot ends in the
    // strobe cycle and is idle only if the byte just sent carried no enable.
    if (slow_q) begin
      boundary = period_end && phase_q && !en_q;
    end else begin
      boundary = !gmii_tx_en;
    end
    adopt = boundary && (req_speed != speed_q);
  end

  // Next core state
  always_comb begin
    speed_d = speed_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    en_d    = en_q;
    er_d    = er_q;
    if (adopt) begin
      speed_d = req_speed;
      cnt_d   = '0;
      phase_d = 1'b0;
      byte_d  = '0;
      en_d    = 1'b0;
      er_d    = 1'b0;
    end else if (!slow_q) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      byte_d  = gmii_txd;
      en_d    = gmii_tx_en;
      er_d    = gmii_tx_er;
    end else begin
      if (period_end) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (clk_en_q) begin
        byte_d = gmii_txd;
        en_d   = gmii_tx_en;
        er_d   = gmii_tx_er;
      end
    end
  end

  // Outputs are computed from the next state so that each registered output
  // lines up with the cnt/phase value of the same cycle.
  logic            slow_d;
  logic [CntW-1:0] last_d;
  logic [CntW-1:0] half_d;
  logic [3:0]      nibble_d;

  always_comb begin
    slow_d     = (speed_d != Spd1G);
    last_d     = (speed_d == Spd100M) ? Last100M : Last10M;
    half_d     = (speed_d == Spd100M) ? Half100M : Half10M;
    nibble_d   = phase_d ? byte_d[7:4] : byte_d[3:0];
    chg_d      = adopt;
    clk_en_d   = 1'b1;
    txc_rise_d = 1'b1;
    txc_fall_d = 1'b0;
    txd_rise_d = byte_d[3:0];
    txd_fall_d = byte_d[7:4];
    ctl_rise_d = en_d;
    ctl_fall_d = en_d ^ er_d;
    if (slow_d) begin
      clk_en_d   = (cnt_d == last_d) && phase_d;
      txc_rise_d = (cnt_d >= half_d);
      txc_fall_d = (cnt_d >= half_d);
      if (cnt_d == '0) begin
        txd_rise_d = nibble_d;
        txd_fall_d = nibble_d;
      end else begin
        txd_rise_d = txd_rise_q;
        txd_fall_d = txd_fall_q;
        ctl_rise_d = ctl_rise_q;
        ctl_fall_d = ctl_fall_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q    <= Spd1G;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      byte_q     <= '0;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      clk_en_q   <= 1'b1;
      txc_rise_q <= 1'b1;
      txc_fall_q <= 1'b0;
      txd_rise_q <= '0;
      txd_fall_q <= '0;
      ctl_rise_q <= 1'b0;
      ctl_fall_q <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
      en_q       <= en_d;
      er_q       <= er_d;
      clk_en_q   <= clk_en_d;
      txc_rise_q <= txc_rise_d;
      txc_fall_q <= txc_fall_d;
      txd_rise_q <= txd_rise_d;
      txd_fall_q <= txd_fall_d;
      ctl_rise_q <= ctl_rise_d;
      ctl_fall_q <= ctl_fall_d;
      chg_q      <= chg_d;
    end
  end

  assign gmii_tx_clk_en = clk_en_q;
  assign txc_d1         = txc_rise_q;
  assign txc_d2         = txc_fall_q;
  assign txd_d1         = txd_rise_q;
  assign txd_d2         = txd_fall_q;
  assign txctl_d1       = ctl_rise_q;
  assign txctl_d2       = ctl_fall_q;
  assign speed_active   = speed_q;
  assign speed_change   = chg_q;

endmodule

// File: tb/tb_rgmii_tx_serializer.sv
// Self-checking bench for rgmii_tx_serializer: random GMII bytes, a
// nibble-level reference model feeding a scoreboard queue, and a monitor that
// pops on every DUT output slot and also checks TXC / strobe timing.
`timescale 1ns/1ps
module tb_rgmii_tx_serializer;

  localparam int unsigned Div100 = 5;
  localparam int unsigned Div10  = 50;
  localparam logic [15:0] RstVec = 16'b1_0_0000_0000_0_0_1_10_0;

  logic       clk;
  logic       rst_n;
  logic [1:0] speed;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       gmii_tx_clk_en;
  logic       txc_d1, txc_d2;
  logic [3:0] txd_d1, txd_d2;
  logic       txctl_d1, txctl_d2;
  logic [1:0] speed_active;
  logic       speed_change;

  rgmii_tx_serializer #(
    .CLK_DIV_100M(Div100),
    .CLK_DIV_10M (Div10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .speed         (speed),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .gmii_tx_clk_en(gmii_tx_clk_en),
    .txc_d1        (txc_d1),
    .txc_d2        (txc_d2),
    .txd_d1        (txd_d1),
    .txd_d2        (txd_d2),
    .txctl_d1      (txctl_d1),
    .txctl_d2      (txctl_d2),
    .speed_active  (speed_active),
    .speed_change  (speed_change)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       c1;
    logic       c2;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       en;
    logic       er;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    errors  = 0;
  int    checks  = 0;
  int    chg_cnt = 0;
  logic [1:0] cur_speed = 2'b10;
  int    cur_div = 0;
  bit    tmg_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [15:0] out_vec();
    return {txc_d1, txc_d2, txd_d1, txd_d2, txctl_d1, txctl_d2,
            gmii_tx_clk_en, speed_active, speed_change};
  endfunction

  // Reference model: a byte becomes one 1G slot or two nibble periods.
  task automatic model_push(input stim_t s);
    exp_t e;
    e.c1 = s.en;
    e.c2 = s.en ^ s.er;
    if (cur_speed == 2'b10) begin
      e.d1 = s.d[3:0];
      e.d2 = s.d[7:4];
      exp_q.push_back(e);
    end else begin
      e.d1 = s.d[3:0];
      e.d2 = s.d[3:0];
      exp_q.push_back(e);
      e.d1 = s.d[7:4];
      e.d2 = s.d[7:4];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_stim(input logic [7:0] d, input logic en, input logic er);
    stim_t s;
    s.d  = d;
    s.en = en;
    s.er = er;
    stim_q.push_back(s);
  endtask

  task automatic add_random(input int n, input bit force_en);
    for (int i = 0; i < n; i++) begin
      push_stim(8'($urandom), force_en ? 1'b1 : ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0));
    end
  endtask

  // Presents queued bytes to the DUT, one per observed strobe.
  task automatic drive(input int limit);
    int    guard;
    stim_t s;
    guard = 0;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      guard++;
      if (guard > limit) begin
        timeout("drive");
        stim_q.delete();
      end else if (gmii_tx_clk_en) begin
        s          = stim_q.pop_front();
        gmii_txd   = s.d;
        gmii_tx_en = s.en;
        gmii_tx_er = s.er;
        model_push(s);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    gmii_txd   = 8'h00;
    gmii_tx_en = 1'b0;
    gmii_tx_er = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      timeout("drain");
      exp_q.delete();
    end
  endtask

  // Counts cycles from the current sample to the first strobe.
  task automatic first_strobe(input string name, input int div);
    int n;
    n = 0;
    while (!gmii_tx_clk_en && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, n, 2 * div - 1);
  endtask

  task automatic adopt_speed(input logic [1:0] spd, input logic [1:0] exp_act, input int div,
                             input string name);
    int n;
    int base;
    tmg_en = 1'b0;
    base   = chg_cnt;
    @(negedge clk);
    speed = spd;
    n = 0;
    while (!speed_change && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({name, "_pulse"}, speed_change, 1);
    chk({name, "_active"}, speed_active, exp_act);
    cur_speed = exp_act;
    if (div != 0) first_strobe({name, "_first_strobe"}, div);
    @(negedge clk);
    chk({name, "_one_pulse"}, chg_cnt - base, 1);
    cur_div = div;
    tmg_en  = 1'b1;
  endtask

  // Monitor: pops the scoreboard at each output slot and checks timing.
  initial begin
    bit   prev_en, prev_txc, run_ok, stb_ok, ev;
    int   run_len, since;
    exp_t e;
    prev_en  = 1'b1;
    prev_txc = 1'b1;
    run_ok   = 1'b0;
    stb_ok   = 1'b0;
    run_len  = 0;
    since    = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_en  = 1'b1;
        prev_txc = 1'b1;
        run_ok   = 1'b0;
        stb_ok   = 1'b0;
      end else begin
        if (speed_change) chg_cnt++;
        if (speed_active == 2'b10) ev = prev_en;
        else ev = !txc_d1 && prev_txc;
        if (ev && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_data", {txd_d1, txd_d2, txctl_d1, txctl_d2}, {e.d1, e.d2, e.c1, e.c2});
        end
        if (!tmg_en) begin
          run_ok = 1'b0;
          stb_ok = 1'b0;
        end else if (cur_div == 0) begin
          chk("g_txc_strobe", {txc_d1, txc_d2, gmii_tx_clk_en}, 3'b101);
        end else begin
          chk("s_ddr_pair", {txc_d1, txd_d1}, {txc_d2, txd_d2});
          if (txc_d1 == prev_txc) begin
            run_len++;
          end else begin
            if (run_ok) begin
              chk(prev_txc ? "s_txc_high" : "s_txc_low", run_len,
                  prev_txc ? (cur_div - cur_div / 2) : (cur_div / 2));
            end
            run_len = 1;
            run_ok  = 1'b1;
          end
          since++;
          if (gmii_tx_clk_en) begin
            if (stb_ok) chk("s_strobe_period", since, 2 * cur_div);
            since  = 0;
            stb_ok = 1'b1;
          end
        end
        prev_en  = gmii_tx_clk_en;
        prev_txc = txc_d1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int n;
    speed = 2'b10;
    set_idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk("reset_outputs", out_vec(), RstVec);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_1g_active", speed_active, 2'b10);
    chk("no_change_same_speed", chg_cnt, 0);

    // 1G: directed preamble/SFD/error byte, then random traffic
    cur_speed = 2'b10;
    cur_div   = 0;
    tmg_en    = 1'b1;
    push_stim(8'h55, 1'b1, 1'b0);
    push_stim(8'hD5, 1'b1, 1'b0);
    push_stim(8'hA3, 1'b1, 1'b1);
    add_random(40, 1'b0);
    drive(200);
    set_idle();
    wait_drain(50);

    // 100M
    adopt_speed(2'b01, 2'b01, Div100, "to_100m");
    push_stim(8'h3C, 1'b1, 1'b0);
    add_random(20, 1'b0);
    drive(1000);
    set_idle();
    wait_drain(100);

    // 10M idle, then a few bytes
    adopt_speed(2'b00, 2'b00, Div10, "to_10m");
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (txctl_d1 || txctl_d2) bad++;
    end
    chk("10m_idle_txctl", bad, 0);
    add_random(4, 1'b0);
    drive(2000);
    set_idle();
    wait_drain(400);

    // 2'b11 is taken as 1G; moving to 2'b10 afterwards is no change
    adopt_speed(2'b11, 2'b10, 0, "to_1g_via_11");
    base = chg_cnt;
    @(negedge clk);
    speed = 2'b10;
    repeat (10) @(negedge clk);
    chk("11_to_10_no_pulse", chg_cnt - base, 0);

    // Deferred change: 64-byte frame, request 100M after byte 10
    base = chg_cnt;
    add_random(10, 1'b1);
    drive(100);
    speed = 2'b01;
    add_random(54, 1'b1);
    drive(200);
    chk("deferred_hold_active", speed_active, 2'b10);
    chk("deferred_hold_pulse", chg_cnt - base, 0);
    tmg_en = 1'b0;
    set_idle();
    @(negedge clk);
    chk("deferred_before_idle_edge", speed_active, 2'b10);
    @(posedge clk);
    #2;
    chk("deferred_adopt", {speed_change, speed_active}, 3'b101);
    cur_speed = 2'b01;
    first_strobe("deferred_first_strobe", Div100);
    repeat (30) @(negedge clk);
    chk("deferred_one_pulse", chg_cnt - base, 1);
    cur_div = Div100;
    tmg_en  = 1'b1;

    // Reset mid-frame at 100M
    add_random(3, 1'b1);
    drive(200);
    repeat (7) @(posedge clk);
    tmg_en = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("reset_async_outputs", out_vec(), RstVec);
    exp_q.delete();
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur_speed = 2'b10;
    chk("reset_release_1g", speed_active, 2'b10);
    @(posedge clk);
    #2;
    chk("release_adopt", {speed_change, speed_active}, 3'b101);
    cur_speed = 2'b01;
    bad = 0;
    n   = 0;
    while (!gmii_tx_clk_en && n < 1000) begin
      if (txd_d1 != 4'h0 || txd_d2 != 4'h0 || txctl_d1 || txctl_d2) bad++;
      @(posedge clk);
      #2;
      n++;
    end
    chk("release_first_strobe", n, 2 * Div100 - 1);
    chk("no_stale_nibble", bad, 0);
    cur_div = Div100;
    tmg_en  = 1'b1;

    // Glitch request within one 1G frame
    adopt_speed(2'b10, 2'b10, 0, "back_to_1g");
    base = chg_cnt;
    add_random(8, 1'b1);
    drive(100);
    speed = 2'b00;
    add_random(8, 1'b1);
    drive(100);
    speed = 2'b10;
    add_random(8, 1'b1);
    drive(100);
    set_idle();
    wait_drain(50);
    repeat (20) @(negedge clk);
    chk("glitch_no_pulse", chg_cnt - base, 0);
    chk("glitch_active", speed_active, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgmii_tx_serializer.md
RGMII_TX_SERIALIZER -- requirements
Module: rgmii_tx_serializer

Interface
REQ-001 Parameter CLK_DIV_100M, default 5: clk cycles per RGMII TXC period at 100M; legal range >= 2.
REQ-002 Parameter CLK_DIV_10M, default 50: clk cycles per RGMII TXC period at 10M; legal range >= 2.
REQ-003 clk  input  1  single clock (125 MHz nominal); every register is clocked on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 speed  input  2  requested speed: 2'b10 = 1G, 2'b01 = 100M, 2'b00 = 10M, 2'b11 = treated as 1G.
REQ-006 gmii_txd / gmii_tx_en / gmii_tx_er  input  8/1/1  MAC byte stream, sampled only when gmii_tx_clk_en = 1.
REQ-007 gmii_tx_clk_en  output  1  byte strobe to the MAC.
REQ-008 txc_d1 / txc_d2  output  1/1  rising-edge and falling-edge bits for the TXC ODDR.
REQ-009 txd_d1 / txd_d2  output  4/4  rising-edge and falling-edge nibbles for the TD ODDR.
REQ-010 txctl_d1 / txctl_d2  output  1/1  rising-edge and falling-edge bits for the TX_CTL ODDR.
REQ-011 speed_active  output  2  speed currently in effect (2'b11 is reported as 2'b10).
REQ-012 speed_change  output  1  one-cycle pulse, asserted in the cycle in which speed_active changes.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 1G mode: gmii_tx_clk_en held at 1.
REQ-015 1G mode: each sampled byte appears on the data outputs 1 cycle after sampling, as follows: txc_d1 = 1, txc_d2 = 0, txd_d1 = txd[3:0], txd_d2 = txd[7:4], txctl_d1 = en, txctl_d2 = en ^ er.
REQ-016 10M/100M mode, period counter: cnt runs 0..DIV-1 and wraps to 0, where DIV is CLK_DIV_10M or CLK_DIV_100M as selected.
REQ-017 10M/100M mode, TXC: txc_d1 = txc_d2 = 0 while cnt < DIV/2 (floor), and 1 otherwise.
REQ-018 10M/100M mode, nibble phase: a phase bit toggles each time cnt wraps to 0; phase 0 carries the low nibble and phase 1 the high nibble.
REQ-019 10M/100M mode, byte strobe: gmii_tx_clk_en = 1 for exactly one cycle per two TXC periods, in the cycle with cnt = DIV-1 and phase = 1; it is 0 in all other cycles.
REQ-020 10M/100M mode, byte capture: the byte, en and er sampled under the strobe are held in a byte register.
REQ-021 10M/100M mode, data update: txd_d1 = txd_d2 = the selected nibble, updated only at cnt = 0; the low nibble is driven in the period immediately after the strobe.
REQ-022 10M/100M mode, control: txctl_d1 = en and txctl_d2 = en ^ er for both nibbles of a byte.
REQ-023 Output widths SHALL be fixed; the internal counter width is $clog2 of the larger divider, with no overflow possible.
REQ-024 Speed change rule: a differing speed input SHALL be adopted only at an idle byte boundary.
REQ-025 Idle byte boundary, 1G: any cycle whose sampled gmii_tx_en = 0.
REQ-026 Idle byte boundary, 10M/100M: cnt = DIV-1, phase = 1 and the held en = 0.
REQ-027 A speed change requested mid-frame SHALL be deferred until the first idle boundary after tx_en falls; no partial byte or truncated TXC period is emitted.
REQ-028 On adoption of a new speed: speed_active updates, speed_change pulses, cnt and phase reset to 0, and the byte register is cleared to en = 0, er = 0, data = 0.
REQ-029 The first strobe at a newly adopted 10M/100M speed occurs 2*DIV cycles after adoption.
REQ-030 If speed toggles away and back before a boundary is reached, no change occurs and no speed_change pulse is produced.

Reset
REQ-031 While rst_n = 0, all outputs SHALL be forced asynchronously to the following values: txc_d1 = 1, txc_d2 = 0, txd_d1/txd_d2 = 0, txctl_d1/txctl_d2 = 0, gmii_tx_clk_en = 1, speed_active = 2'b10, speed_change = 0.
REQ-032 While rst_n = 0, cnt, phase and the byte register SHALL be cleared.
REQ-033 On release, the block starts in 1G mode and adopts the speed input at the first idle boundary, pulsing speed_change if it differs.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately; no stale nibble is driven after release.

Verification
REQ-035 1G frame: speed = 2'b10; bytes 0x55, 0xD5, then 0xA3 with er = 1 -> one cycle later txd_d1/txd_d2 = 5/5, 5/D, 3/A; txctl_d2 = 0 on the 0xA3 byte; gmii_tx_clk_en held at 1.
REQ-036 100M, DIV = 5: byte 0x3C, en = 1 -> strobe every 10 cycles; TXC low 2 cycles, high 3 cycles; txd = C for one period, then 3; txctl_d1 = txctl_d2 = 1.
REQ-037 10M, DIV = 50: idle stream -> strobe period 100 cycles; TXC low 25 cycles, high 25 cycles; txctl = 0.
REQ-038 Deferred change: speed switched from 2'b10 to 2'b01 during a 64-byte frame -> speed_active stays 2'b10 until the cycle after tx_en falls; then exactly one speed_change pulse; first strobe 10 cycles later.
REQ-039 Reset mid-frame at 100M: rst_n low for 3 cycles, asynchronous to the clock edge -> outputs take their reset values immediately; speed_active = 2'b10 after release.
REQ-040 Glitch request: speed 2'b10 -> 2'b00 -> 2'b10 within one frame -> no speed_change pulse; TXC pattern unchanged.
